// File: rtl/sample_capture_pkg.sv
// Shared types, default sizes and helpers for the sample capture controller.
// Optional trigger support is enabled in the top by SAMPLE_CAPTURE_TRIGGER_EN.
package sample_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int CAP_ADDR_W = 16;
  localparam int CAP_DATA_W = 24;
  localparam int CAP_DEPTH  = 48000;

  function automatic logic [31:0] sext24to32(input logic [23:0] d);
    return {{8{d[23]}}, d};
  endfunction

endpackage

// File: rtl/sample_capture_ctrl_host_read_pipe.sv
// Two-stage host read pipeline: registers the BRAM read address, tracks
// validity and range, and sign-extends the returned sample to 32 bits.
module host_read_pipe
  import sample_capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rdReq,
  input  logic [ADDR_W-1:0] i_rdAddr,
  input  logic [ADDR_W-1:0] i_count,
  input  logic [DATA_W-1:0] i_bramDataOut,
  output logic [ADDR_W-1:0] o_bramRa,
  output logic              o_rdValid,
  output logic [31:0]       o_rdData
);

  logic              r_valid1;
  logic              r_valid2;
  logic              r_inRange1;
  logic              r_inRange2;
  logic [ADDR_W-1:0] r_bramRa;

  // Range is judged against the sample count at request time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid1   <= 1'b0;
      r_valid2   <= 1'b0;
      r_inRange1 <= 1'b0;
      r_inRange2 <= 1'b0;
      r_bramRa   <= '0;
    end else begin
      r_valid1   <= i_rdReq;
      r_valid2   <= r_valid1;
      r_inRange1 <= i_rdAddr < i_count;
      r_inRange2 <= r_inRange1;
      if (i_rdReq) begin
        r_bramRa <= i_rdAddr;
      end
    end
  end

  assign o_bramRa  = r_bramRa;
  assign o_rdValid = r_valid2;
  assign o_rdData  = (r_valid2 && r_inRange2) ? sext24to32(24'(i_bramDataOut)) : 32'd0;

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture sequencer for mono samples into the sample BRAM plus host read port.
// Define SAMPLE_CAPTURE_TRIGGER_EN to add the level-triggered ARMED state.
module sample_capture_ctrl
  import sample_capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = CAP_DEPTH
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  ,
  parameter logic [DATA_W-1:0] TRIG_LEVEL = 24'h010000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] limit,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_valid,
  output logic [31:0]       host_rd_data,
  output logic [ADDR_W-1:0] bram_wa,
  output logic              bram_write,
  output logic [DATA_W-1:0] bram_data_in,
  output logic [ADDR_W-1:0] bram_ra,
  input  logic [DATA_W-1:0] bram_data_out
);

  cap_state_t        r_state;
  cap_state_t        w_nextState;
  cap_state_t        w_startState;
  logic [ADDR_W-1:0] r_lim;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_limClamped;
  logic              w_startOk;
  logic              w_trigHit;
  logic              w_doWrite;
  logic              w_lastSample;

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  logic [DATA_W-1:0] w_absSample;

  // Magnitude of the most negative sample saturates to the largest positive.
  always_comb begin
    w_absSample = sample_in;
    if (sample_in[DATA_W-1]) begin
      if (sample_in == {1'b1, {(DATA_W-1){1'b0}}}) begin
        w_absSample = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        w_absSample = -sample_in;
      end
    end
  end

  assign w_trigHit    = w_absSample >= TRIG_LEVEL;
  assign w_startState = ARMED;
`else
  assign w_trigHit    = 1'b0;
  assign w_startState = CAPTURE;
`endif

  assign w_limClamped = (limit > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : limit;
  assign w_startOk    = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_doWrite    = advance && !abort && (r_count < r_lim) &&
                        ((r_state == CAPTURE) || ((r_state == ARMED) && w_trigHit));
  assign w_lastSample = (r_count + ADDR_W'(1)) == r_lim;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_startOk) begin
          w_nextState = (w_limClamped == '0) ? DONE : w_startState;
        end
      end
      ARMED, CAPTURE: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_doWrite) begin
          w_nextState = w_lastSample ? DONE : CAPTURE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ARMED, CAPTURE: busy = 1'b1;
      DONE:           done = 1'b1;
      default:        ;
    endcase
  end

  // Write port is a registered single-cycle pulse per captured sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lim        <= '0;
      r_count      <= '0;
      bram_write   <= 1'b0;
      bram_wa      <= '0;
      bram_data_in <= '0;
    end else begin
      bram_write <= w_doWrite;
      if (w_startOk) begin
        r_lim   <= w_limClamped;
        r_count <= '0;
      end else if (w_doWrite) begin
        bram_wa      <= r_count;
        bram_data_in <= sample_in;
        r_count      <= r_count + ADDR_W'(1);
      end
    end
  end

  assign count = r_count;

  host_read_pipe #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_hostReadPipe (
    .clk          (clk),
    .reset        (reset),
    .i_rdReq      (host_rd_req),
    .i_rdAddr     (host_rd_addr),
    .i_count      (r_count),
    .i_bramDataOut(bram_data_out),
    .o_bramRa     (bram_ra),
    .o_rdValid    (host_rd_valid),
    .o_rdData     (host_rd_data)
  );

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Scoreboard bench for sample_capture_ctrl with a behavioural dual-port BRAM.
// Honors SAMPLE_CAPTURE_TRIGGER_EN to pick the trigger-scenario expectations.
module tb_sample_capture_ctrl;

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  logic [23:0] sample_in;
  logic        start;
  logic [15:0] limit;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic        host_rd_req;
  logic [15:0] host_rd_addr;
  logic        host_rd_valid;
  logic [31:0] host_rd_data;
  logic [15:0] bram_wa;
  logic        bram_write;
  logic [23:0] bram_data_in;
  logic [15:0] bram_ra;
  logic [23:0] bram_data_out;

  logic [23:0] mem [0:65535];
  wr_t         expWrQ[$];
  logic [31:0] expRdQ[$];
  wr_t         monWr;
  logic [31:0] monRd;
  int          assertCount = 0;
  int          failCount   = 0;

  always #5 clk = ~clk;

  sample_capture_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .advance      (advance),
    .sample_in    (sample_in),
    .start        (start),
    .limit        (limit),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .count        (count),
    .host_rd_req  (host_rd_req),
    .host_rd_addr (host_rd_addr),
    .host_rd_valid(host_rd_valid),
    .host_rd_data (host_rd_data),
    .bram_wa      (bram_wa),
    .bram_write   (bram_write),
    .bram_data_in (bram_data_in),
    .bram_ra      (bram_ra),
    .bram_data_out(bram_data_out)
  );

  // Read-before-write BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bram_write) mem[bram_wa] <= bram_data_in;
    bram_data_out <= mem[bram_ra];
  end

  // Monitor: every write pulse and read response is matched against the queues.
  always @(negedge clk) begin
    if (bram_write) begin
      assertCount++;
      if (expWrQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL bram_write unexpected: actual addr=%0d data=%h, required no write", bram_wa, bram_data_in);
      end else begin
        monWr = expWrQ.pop_front();
        if (bram_wa !== monWr.addr || bram_data_in !== monWr.data) begin
          failCount++;
          $display("[TB] FAIL bram_write: actual addr=%0d data=%h, required addr=%0d data=%h",
                   bram_wa, bram_data_in, monWr.addr, monWr.data);
        end
      end
    end
    if (host_rd_valid) begin
      assertCount++;
      if (expRdQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL host_rd unexpected: actual data=%h, required no response", host_rd_data);
      end else begin
        monRd = expRdQ.pop_front();
        if (host_rd_data !== monRd) begin
          failCount++;
          $display("[TB] FAIL host_rd: actual data=%h, required %h", host_rd_data, monRd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  task automatic doStart(input logic [15:0] lim);
    start = 1'b1;
    limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] s, input bit expWr, input logic [15:0] expAddr);
    if (expWr) expWrQ.push_back('{addr: expAddr, data: s});
    advance   = 1'b1;
    sample_in = s;
    tick();
    advance = 1'b0;
  endtask

  task automatic hostRead(input logic [15:0] addr, input logic [31:0] expData);
    expRdQ.push_back(expData);
    host_rd_req  = 1'b1;
    host_rd_addr = addr;
    tick();
    host_rd_req = 1'b0;
  endtask

  task automatic checkStatus(input string name, input logic expBusy, input logic expDone, input logic [15:0] expCount);
    checkOutput({name, "_busy"}, 32'(busy), 32'(expBusy));
    checkOutput({name, "_done"}, 32'(done), 32'(expDone));
    checkOutput({name, "_count"}, 32'(count), 32'(expCount));
  endtask

  initial begin
    reset = 1'b1; advance = 1'b0; sample_in = '0; start = 1'b0; limit = '0;
    abort = 1'b0; host_rd_req = 1'b0; host_rd_addr = '0;
    repeat (3) tick();
    checkStatus("reset", 1'b0, 1'b0, 16'd0);
    checkOutput("reset_bram_write", 32'(bram_write), 32'd0);
    checkOutput("reset_bram_wa", 32'(bram_wa), 32'd0);
    checkOutput("reset_bram_ra", 32'(bram_ra), 32'd0);
    checkOutput("reset_rd_valid", 32'(host_rd_valid), 32'd0);
    checkOutput("reset_rd_data", host_rd_data, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] capture of four samples");
    doStart(16'd4);
    checkStatus("cap4_started", 1'b1, 1'b0, 16'd0);
    applyStimulus(24'd1, 1'b1, 16'd0);
    applyStimulus(24'd2, 1'b1, 16'd1);
    applyStimulus(24'd3, 1'b1, 16'd2);
    applyStimulus(24'hFFFFFF, 1'b1, 16'd3);
    checkStatus("cap4_done", 1'b0, 1'b1, 16'd4);
    applyStimulus(24'd7, 1'b0, 16'd0);
    hostRead(16'd3, 32'hFFFFFFFF);
    hostRead(16'd4, 32'h00000000);
    hostRead(16'd0, 32'h00000001);
    hostRead(16'd1, 32'h00000002);
    repeat (4) tick();
    checkStatus("cap4_hold", 1'b0, 1'b1, 16'd4);

    $display("[TB] zero limit");
    doStart(16'd0);
    checkStatus("lim0", 1'b0, 1'b1, 16'd0);
    applyStimulus(24'd9, 1'b0, 16'd0);

    $display("[TB] abort mid-capture");
    doStart(16'd10);
    for (int i = 0; i < 5; i++) applyStimulus(24'(16 + i), 1'b1, 16'(i));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkStatus("abort", 1'b0, 1'b0, 16'd5);
    applyStimulus(24'd99, 1'b0, 16'd0);
    start = 1'b1; abort = 1'b1; limit = 16'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    checkStatus("start_abort", 1'b0, 1'b0, 16'd5);
    hostRead(16'd4, 32'd20);
    hostRead(16'd5, 32'd0);
    repeat (4) tick();

    $display("[TB] reset mid-capture");
    doStart(16'd10);
    for (int i = 0; i < 3; i++) applyStimulus(24'(32 + i), 1'b1, 16'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkStatus("midreset", 1'b0, 1'b0, 16'd0);
    checkOutput("midreset_bram_write", 32'(bram_write), 32'd0);
    checkOutput("midreset_bram_wa", 32'(bram_wa), 32'd0);
    checkOutput("midreset_bram_data", 32'(bram_data_in), 32'd0);
    applyStimulus(24'd40, 1'b0, 16'd0);
    applyStimulus(24'd41, 1'b0, 16'd0);
    checkStatus("midreset_after", 1'b0, 1'b0, 16'd0);

    $display("[TB] trigger scenario");
    doStart(16'd2);
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    applyStimulus(24'h000100, 1'b0, 16'd0);
    checkStatus("trig_armed", 1'b1, 1'b0, 16'd0);
    applyStimulus(24'hFE0000, 1'b1, 16'd0);
    applyStimulus(24'h000005, 1'b1, 16'd1);
    checkStatus("trig_done", 1'b0, 1'b1, 16'd2);
    hostRead(16'd0, 32'hFFFE0000);
    hostRead(16'd1, 32'h00000005);
`else
    applyStimulus(24'h000100, 1'b1, 16'd0);
    applyStimulus(24'hFE0000, 1'b1, 16'd1);
    checkStatus("notrig_done", 1'b0, 1'b1, 16'd2);
    applyStimulus(24'h000005, 1'b0, 16'd0);
    hostRead(16'd0, 32'h00000100);
    hostRead(16'd1, 32'hFFFE0000);
`endif
    repeat (4) tick();

    $display("[TB] limit clamp");
    doStart(16'hFFFF);
    for (int i = 0; i < 48001; i++) applyStimulus(24'(i), i < 48000, 16'(i));
    checkStatus("clamp", 1'b0, 1'b1, 16'd48000);
    hostRead(16'd47999, 32'h0000BB7F);
    hostRead(16'd48000, 32'h00000000);
    repeat (4) tick();

    checkOutput("write_queue_drained", 32'(expWrQ.size()), 32'd0);
    checkOutput("read_queue_drained", 32'(expRdQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
